// File: rtl/regfile_ctx_ctrl_pkg.sv
// Shared constants and FSM state type for the register-file context-switch sequencer.
package regfile_ctx_ctrl_pkg;

  localparam int RNUM        = 32;
  localparam int RADDR_WIDTH = $clog2(RNUM);
  localparam int RDATA_WIDTH = 32;
  localparam int CTX_WORDS   = 31;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG  = '0;
  localparam logic [RADDR_WIDTH-1:0] FIRST_REG = RADDR_WIDTH'(1);
  localparam logic [RADDR_WIDTH-1:0] LAST_REG  = RADDR_WIDTH'(CTX_WORDS);

  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_R_REQ,
    ST_R_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/regfile_ctx_ctrl_dirty_map.sv
// Dirty bitmap of x1..x31 with lowest-dirty and next-dirty-after-idx priority encoders.
// Only instantiated when REGFILE_CTX_DIRTY_EN is defined.
module regfile_dirty_map
  import regfile_ctx_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [RADDR_WIDTH-1:0] set_addr,
  input  logic                   clear,
  input  logic [RADDR_WIDTH-1:0] cur_idx,
  output logic [RADDR_WIDTH-1:0] first_idx,
  output logic                   first_valid,
  output logic [RADDR_WIDTH-1:0] next_idx,
  output logic                   next_valid
);

  logic [RNUM-1:1] map_q;
  logic [RNUM-1:1] set_vec;
  logic [RNUM-1:1] eff_map;

  always_comb begin
    set_vec = '0;
    for (int i = 1; i < RNUM; i++) begin
      set_vec[i] = set_en && (set_addr == RADDR_WIDTH'(i));
    end
  end

  // A write snooped in the same cycle as the switch request still counts as dirty.
  assign eff_map = map_q | set_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
    end else if (clear) begin
      map_q <= '0;
    end else begin
      map_q <= map_q | set_vec;
    end
  end

  always_comb begin
    first_idx   = ZERO_REG;
    first_valid = 1'b0;
    next_idx    = ZERO_REG;
    next_valid  = 1'b0;
    for (int i = RNUM - 1; i >= 1; i--) begin
      if (eff_map[i]) begin
        first_idx   = RADDR_WIDTH'(i);
        first_valid = 1'b1;
      end
      if (map_q[i] && (RADDR_WIDTH'(i) > cur_idx)) begin
        next_idx   = RADDR_WIDTH'(i);
        next_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_ctx_ctrl.sv
// Task-switch sequencer: saves x1..x31 of the outgoing task, then restores the incoming task.
// Optional REGFILE_CTX_DIRTY_EN adds snoop ports so that only written registers are saved.
module regfile_ctx_ctrl
  import regfile_ctx_ctrl_pkg::*;
#(
  parameter int          TASK_ID_W  = 2,
  parameter logic [31:0] CTX_BASE   = 32'h0000_1000,
  parameter int          CTX_STRIDE = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sw_req_i,
  input  logic [TASK_ID_W-1:0]   sw_from_i,
  input  logic [TASK_ID_W-1:0]   sw_to_i,
  output logic                   stall_o,
  output logic                   sw_done_o,
  output logic                   rf_re_o,
  output logic [RADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [RDATA_WIDTH-1:0] rf_rdata_i,
  output logic                   rf_we_o,
  output logic [RADDR_WIDTH-1:0] rf_waddr_o,
  output logic [RDATA_WIDTH-1:0] rf_wdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [RDATA_WIDTH-1:0] mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] mem_rdata_i
`ifdef REGFILE_CTX_DIRTY_EN
  ,
  input  logic                   snoop_we_i,
  input  logic [RADDR_WIDTH-1:0] snoop_waddr_i
`endif
);

  state_t                 state_q, state_d;
  logic [RADDR_WIDTH-1:0] idx_q, idx_d;
  logic [TASK_ID_W-1:0]   from_q, to_q;
  logic                   load;
  logic [31:0]            from_base, to_base, word_off;

  logic [RADDR_WIDTH-1:0] first_idx, next_idx;
  logic                   first_valid, next_valid;

`ifdef REGFILE_CTX_DIRTY_EN
  regfile_dirty_map u_dirty_map (
    .clk         (clk_i),
    .rst_n       (rst_i),
    .set_en      (snoop_we_i && !stall_o),
    .set_addr    (snoop_waddr_i),
    .clear       (state_q == ST_DONE),
    .cur_idx     (idx_q),
    .first_idx   (first_idx),
    .first_valid (first_valid),
    .next_idx    (next_idx),
    .next_valid  (next_valid)
  );
`else
  assign first_idx   = FIRST_REG;
  assign first_valid = 1'b1;
  assign next_idx    = idx_q + RADDR_WIDTH'(1);
  assign next_valid  = (idx_q != LAST_REG);
`endif

  // Context addresses wrap modulo 2^32 by construction of the 32-bit sums.
  assign from_base = CTX_BASE + 32'(from_q) * 32'(CTX_STRIDE);
  assign to_base   = CTX_BASE + 32'(to_q) * 32'(CTX_STRIDE);
  assign word_off  = {{(32 - RADDR_WIDTH - 2){1'b0}}, idx_q, 2'b00};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST_REG;
      from_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        from_q <= sw_from_i;
        to_q   <= sw_to_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load        = 1'b0;
    stall_o     = 1'b0;
    sw_done_o   = 1'b0;
    rf_re_o     = 1'b0;
    rf_raddr_o  = ZERO_REG;
    rf_we_o     = 1'b0;
    rf_waddr_o  = ZERO_REG;
    rf_wdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (sw_req_i) begin
          load  = 1'b1;
          idx_d = FIRST_REG;
          if (sw_from_i == sw_to_i) begin
            state_d = ST_DONE;
          end else if (first_valid) begin
            state_d = ST_SAVE;
            idx_d   = first_idx;
          end else begin
            state_d = ST_R_REQ;
          end
        end
      end
      ST_SAVE: begin
        stall_o     = 1'b1;
        rf_re_o     = READ_ENABLE;
        rf_raddr_o  = idx_q;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = from_base + word_off;
        mem_wdata_o = rf_rdata_i;
        if (mem_gnt_i) begin
          if (next_valid) begin
            idx_d = next_idx;
          end else begin
            idx_d   = FIRST_REG;
            state_d = ST_R_REQ;
          end
        end
      end
      ST_R_REQ: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = to_base + word_off;
        if (mem_gnt_i) begin
          state_d = ST_R_WAIT;
        end
      end
      ST_R_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          rf_we_o    = WRITE_ENABLE;
          rf_waddr_o = idx_q;
          rf_wdata_o = mem_rdata_i;
          if (idx_q == LAST_REG) begin
            idx_d   = FIRST_REG;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + RADDR_WIDTH'(1);
            state_d = ST_R_REQ;
          end
        end
      end
      ST_DONE: begin
        stall_o   = 1'b1;
        sw_done_o = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
